// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and output saturation helper for the binary conv stage.
package cnn_pkg;

    localparam int FMAP_DIM    = 26;
    localparam int FMAP_LEN    = FMAP_DIM * FMAP_DIM;
    localparam int N_TAPS      = 9;
    localparam int WT_PER_FILT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAP  = 2'd1,
        OUT  = 2'd2,
        FULL = 2'd3
    } conv_state_t;

    // Negative sums clamp to zero (ReLU); anything above a byte clamps to 255.
    function automatic logic [7:0] relu_sat8(input logic signed [31:0] acc);
        if (acc < 0) begin
            return 8'd0;
        end
        if (acc > 255) begin
            return 8'hFF;
        end
        return acc[7:0];
    endfunction

endpackage

// File: rtl/cnn_conv_window_if.sv
// Window-reader handshake, weight-load port and feature-map write bus of the conv stage.
interface cnn_conv_window_if #(
    parameter int N_FILT = 4
);
    logic                  frame_clr;
    logic                  strt;
    logic                  din;
    logic                  bsy;
    logic                  wt_we;
    logic [5:0]            wt_addr;
    logic [7:0]            wt_din;
    logic                  fm_wr;
    logic [9:0]            fm_addr;
    logic [8*N_FILT-1:0]   fm_data;
    logic                  frame_done;

    modport master (
        output frame_clr, strt, din, wt_we, wt_addr, wt_din,
        input  bsy, fm_wr, fm_addr, fm_data, frame_done
    );

    modport slave (
        input  frame_clr, strt, din, wt_we, wt_addr, wt_din,
        output bsy, fm_wr, fm_addr, fm_data, frame_done
    );
endinterface

// File: rtl/cnn_conv_mac.sv
// One filter: 9 tap weights plus bias, a serial signed accumulator and ReLU/saturation.
module cnn_conv_mac
    import cnn_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] tap,
    input  logic       en,
    input  logic       din,
    input  logic       wt_we,
    input  logic [3:0] wt_idx,
    input  logic [7:0] wt_din,
    output logic [7:0] q
);

    logic [7:0]              wt_q [WT_PER_FILT];
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] base_w;
    logic signed [ACC_W-1:0] term_w;

    // The bias is folded in on tap 0 rather than at accept, so a bias written
    // on the accept cycle is still used by that window. q reflects the sum
    // including the current tap, letting the top register it on the last tap.
    always_comb begin
        term_w = din ? {{(ACC_W-8){wt_q[tap][7]}}, wt_q[tap]} : '0;
        base_w = ld ? {{(ACC_W-8){wt_q[N_TAPS][7]}}, wt_q[N_TAPS]} : acc_q;
        acc_d  = en ? base_w + term_w : acc_q;
        q      = relu_sat8(32'(acc_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Weights survive frame restarts; only the async reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WT_PER_FILT; i++) begin
                wt_q[i] <= '0;
            end
        end else if (wt_we) begin
            wt_q[wt_idx] <= wt_din;
        end
    end

endmodule

// File: rtl/cnn_conv_window.sv
// Binary 3x3 convolution stage: consumes serial windows, writes one packed ReLU byte per filter.
module cnn_conv_window
    import cnn_pkg::*;
#(
    parameter int N_FILT = 4,
    parameter int ACC_W  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    cnn_conv_window_if.slave conv_if
);

    localparam logic [6:0] WT_LIMIT   = 7'(WT_PER_FILT * N_FILT);
    localparam logic [9:0] FMAP_LEN_C = 10'(FMAP_LEN);
    localparam logic [9:0] LAST_IDX   = 10'(FMAP_LEN - 1);
    localparam logic [3:0] LAST_TAP   = 4'(N_TAPS - 1);

    conv_state_t         state_q;
    logic [3:0]          tap_q;
    logic [9:0]          count_q;
    logic                bsy_q;
    logic                fm_wr_q;
    logic [9:0]          fm_addr_q;
    logic [8*N_FILT-1:0] fm_data_q;
    logic                frame_done_q;

    logic                accept_w;
    logic                tap_en_w;
    logic                last_tap_w;
    logic                wt_ok_w;
    logic [5:0]          wt_filt_w;
    logic [3:0]          wt_idx_w;
    logic [7:0]          mac_q [N_FILT];
    logic [8*N_FILT-1:0] fm_data_d;

    assign accept_w   = (state_q == IDLE) && conv_if.strt && !bsy_q && (count_q < FMAP_LEN_C);
    assign tap_en_w   = (state_q == TAP);
    assign last_tap_w = tap_en_w && (tap_q == LAST_TAP);

    // Weight writes are refused mid-window so a window never sees a half-updated filter.
    assign wt_ok_w   = conv_if.wt_we && !bsy_q && ({1'b0, conv_if.wt_addr} < WT_LIMIT);
    assign wt_filt_w = 6'(conv_if.wt_addr / 6'd10);
    assign wt_idx_w  = 4'(conv_if.wt_addr % 6'd10);

    for (genvar f = 0; f < N_FILT; f++) begin : g_mac
        cnn_conv_mac #(
            .ACC_W (ACC_W)
        ) u_mac (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (conv_if.frame_clr),
            .ld     (tap_q == 4'd0),
            .tap    (tap_q),
            .en     (tap_en_w),
            .din    (conv_if.din),
            .wt_we  (wt_ok_w && (wt_filt_w == 6'(f))),
            .wt_idx (wt_idx_w),
            .wt_din (conv_if.wt_din),
            .q      (mac_q[f])
        );
    end

    always_comb begin
        fm_data_d = '0;
        for (int f = 0; f < N_FILT; f++) begin
            fm_data_d[8*f +: 8] = mac_q[f];
        end
    end

    // Control FSM. The result is captured on the edge that consumes tap 8, so
    // the write strobe is visible during OUT; count advances on that same edge
    // and OUT decides between IDLE and FULL from the already-advanced count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tap_q        <= '0;
            count_q      <= '0;
            bsy_q        <= 1'b0;
            fm_wr_q      <= 1'b0;
            fm_addr_q    <= '0;
            fm_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else if (conv_if.frame_clr) begin
            state_q      <= IDLE;
            tap_q        <= '0;
            count_q      <= '0;
            bsy_q        <= 1'b0;
            fm_wr_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            fm_wr_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_w) begin
                        state_q <= TAP;
                        tap_q   <= '0;
                        bsy_q   <= 1'b1;
                    end
                end
                TAP: begin
                    tap_q <= tap_q + 4'd1;
                    if (last_tap_w) begin
                        state_q      <= OUT;
                        fm_wr_q      <= 1'b1;
                        fm_addr_q    <= count_q;
                        fm_data_q    <= fm_data_d;
                        frame_done_q <= (count_q == LAST_IDX);
                        count_q      <= count_q + 10'd1;
                    end
                end
                OUT: begin
                    bsy_q   <= 1'b0;
                    state_q <= (count_q == FMAP_LEN_C) ? FULL : IDLE;
                end
                FULL: begin
                    bsy_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign conv_if.bsy        = bsy_q;
    assign conv_if.fm_wr      = fm_wr_q;
    assign conv_if.fm_addr    = fm_addr_q;
    assign conv_if.fm_data    = fm_data_q;
    assign conv_if.frame_done = frame_done_q;

endmodule
